fifo_wr_arbiter: RTL and testbench

- Write-side controller for the asynchronous FIFO RAM, running entirely in the w_clk domain.
- Shares the RAM write port between two producers using round-robin arbitration with a bounded burst length.
- Owns the binary write pointer and its Gray-coded copy, and computes the registered full flag against the read pointer.
- The read pointer arrives already synchronized into w_clk.
- Drives the RAM's Write_EN, write_addr and DataIn directly; exports wptr_gray to the read-domain synchronizer.

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write side of the async FIFO: round-robin arbitration between two
// producers, write/Gray pointer ownership and the registered full flag.
module fifo_wr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  w_clk,
    input  logic                  rst_n,
    input  logic                  valid0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ready0,
    input  logic                  valid1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ready1,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic                  Write_EN,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] DataIn,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  grant_id
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     burst_cnt;
    logic [CW-1:0]     burst_nxt;
    logic              rr_last;
    logic              rr_nxt;
    logic              grant;
    logic              keep0;
    logic              keep1;
    logic              burst_open;
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_nxt;
    logic [ADDR_WIDTH:0] wgray_nxt;
    logic [ADDR_WIDTH:0] rgray_full;
    logic              full_nxt;

    // Grant selection: owner keeps it until its burst is spent and the
    // other side waits; otherwise a lone requester or the round-robin
    // choice wins, so a release never costs a bubble cycle.
    always_comb begin
        burst_open = (burst_cnt < CW'(MAX_BURST));
        keep0      = (state == OWN0) && valid0 && (burst_open || !valid1);
        keep1      = (state == OWN1) && valid1 && (burst_open || !valid0);
        grant      = ~rr_last;
        if (keep0) begin
            grant = 1'b0;
        end else if (keep1) begin
            grant = 1'b1;
        end else if (valid0 && !valid1) begin
            grant = 1'b0;
        end else if (valid1 && !valid0) begin
            grant = 1'b1;
        end
    end

    // Handshake and RAM-port drive; reset masks the accept so nothing
    // is written while rst_n is low.
    always_comb begin
        ready0     = (grant == 1'b0) && valid0 && !full && rst_n;
        ready1     = (grant == 1'b1) && valid1 && !full && rst_n;
        Write_EN   = ready0 | ready1;
        DataIn     = grant ? data1 : data0;
        grant_id   = grant;
        write_addr = wbin[ADDR_WIDTH-1:0];
    end

    // Next FSM state, burst count and round-robin memory.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        rr_nxt    = rr_last;
        if (Write_EN) begin
            state_nxt = grant ? OWN1 : OWN0;
            rr_nxt    = grant;
            if (state != state_nxt) begin
                burst_nxt = CW'(1);
            end else if (burst_cnt != CW'(MAX_BURST)) begin
                burst_nxt = burst_cnt + CW'(1);
            end
        end else if (!full) begin
            if ((state == OWN0 && !valid0) || (state == OWN1 && !valid1)) begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        end
    end

    // Pointer advance and full detection against the synced read pointer.
    always_comb begin
        wbin_nxt   = wbin + {{ADDR_WIDTH{1'b0}}, Write_EN};
        wgray_nxt  = wbin_nxt ^ (wbin_nxt >> 1);
        rgray_full = {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                      rptr_gray_sync[ADDR_WIDTH-2:0]};
        full_nxt   = (wgray_nxt == rgray_full);
    end

    // Arbiter state registers.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_last   <= 1'b1;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            rr_last   <= rr_nxt;
        end
    end

    // Write pointer, its Gray copy and the full flag.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
        end else begin
            wbin      <= wbin_nxt;
            wptr_gray <= wgray_nxt;
            full      <= full_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued as
// stimulus is driven and compared when the DUT asserts Write_EN.
module tb_fifo_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          w_clk = 1'b0;
    logic          rst_n;
    logic          valid0, valid1;
    logic [DW-1:0] data0, data1;
    logic          ready0, ready1;
    logic [AW:0]   rptr_gray_sync;
    logic          Write_EN;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] DataIn;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          grant_id;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          gid;
    } wr_t;

    wr_t exp_q[$];
    wr_t e_cur;
    int  n_vec = 0;
    int  n_bad = 0;

    fifo_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .w_clk(w_clk), .rst_n(rst_n),
        .valid0(valid0), .data0(data0), .ready0(ready0),
        .valid1(valid1), .data1(data1), .ready1(ready1),
        .rptr_gray_sync(rptr_gray_sync),
        .Write_EN(Write_EN), .write_addr(write_addr), .DataIn(DataIn),
        .wptr_gray(wptr_gray), .full(full), .grant_id(grant_id)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk(input int a, input int d, input logic g);
        wr_t w;
        w.addr = AW'(a);
        w.data = DW'(d);
        w.gid  = g;
        return w;
    endfunction

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    // Scoreboard side: every accepted write must match the queue head.
    always @(negedge w_clk) begin
        if (rst_n && Write_EN) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {26'd0, write_addr}, 32'hFFFF_FFFF);
            end else begin
                e_cur = exp_q.pop_front();
                check("wr_addr", {27'd0, write_addr}, {27'd0, e_cur.addr});
                check("wr_data", {24'd0, DataIn}, {24'd0, e_cur.data});
                check("wr_grant", {31'd0, grant_id}, {31'd0, e_cur.gid});
            end
        end
    end

    task automatic wait_accept(input int who);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge w_clk);
            if ((who == 0) ? ready0 : ready1) ok = 1'b1;
            @(posedge w_clk);
            #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic both_cycles(input int n);
        logic r0, r1;
        for (int i = 0; i < n; i++) begin
            @(negedge w_clk);
            check("no_bubble", {31'd0, Write_EN}, 1);
            r0 = ready0;
            r1 = ready1;
            @(posedge w_clk);
            #1;
            if (r0) data0 = data0 + 8'd1;
            if (r1) data1 = data1 + 8'd1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_wptr_gray", {26'd0, wptr_gray}, 0);
        check("rst_full", {31'd0, full}, 0);
        check("rst_write_en", {31'd0, Write_EN}, 0);
        check("rst_readys", {30'd0, ready1, ready0}, 0);
        @(posedge w_clk);
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic q_drained(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [AW:0] prev_gray;
    int seq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        int c0, c1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0 = '0;
        data1 = '0;
        rptr_gray_sync = '0;
        reset_dut();

        // Fill the empty FIFO from requester 0.
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(mk(i, i, 1'b0));
            valid0 = 1'b1;
            data0 = DW'(i);
            wait_accept(0);
        end
        data0 = 8'hA5;
        @(negedge w_clk);
        check("fill_full", {31'd0, full}, 1);
        check("fill_ready0", {31'd0, ready0}, 0);
        check("fill_write_en", {31'd0, Write_EN}, 0);
        check("fill_wptr_gray", {26'd0, wptr_gray}, 32'b110000);
        @(posedge w_clk);
        #1;

        // One slot frees up: one write, then full again.
        rptr_gray_sync = 6'd1;
        exp_q.push_back(mk(0, 8'hA5, 1'b0));
        @(negedge w_clk);
        check("rel_full_hold", {31'd0, full}, 1);
        check("rel_we_hold", {31'd0, Write_EN}, 0);
        @(posedge w_clk);
        #1;
        @(negedge w_clk);
        check("rel_full_clear", {31'd0, full}, 0);
        check("rel_we", {31'd0, Write_EN}, 1);
        @(posedge w_clk);
        #1;
        check("rel_full_again", {31'd0, full}, 1);
        check("rel_wptr_gray", {26'd0, wptr_gray}, 32'b110001);
        check("rel_we_off", {31'd0, Write_EN}, 0);
        valid0 = 1'b0;
        q_drained("fill_q_drained");

        // Round-robin with both requesters busy.
        rptr_gray_sync = '0;
        reset_dut();
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 12; k++) begin
            if (seq[k] == 0) begin
                exp_q.push_back(mk(k, 8'h40 + c0, 1'b0));
                c0++;
            end else begin
                exp_q.push_back(mk(k, 8'h80 + c1, 1'b1));
                c1++;
            end
        end
        data0 = 8'h40;
        data1 = 8'h80;
        valid0 = 1'b1;
        valid1 = 1'b1;
        both_cycles(12);
        valid0 = 1'b0;
        valid1 = 1'b0;
        q_drained("rr_q_drained");

        // Owner drops after two words; the other side takes over at once.
        reset_dut();
        valid0 = 1'b1;
        data0 = 8'h11;
        exp_q.push_back(mk(0, 8'h11, 1'b0));
        wait_accept(0);
        data0 = 8'h12;
        exp_q.push_back(mk(1, 8'h12, 1'b0));
        wait_accept(0);
        valid0 = 1'b0;
        valid1 = 1'b1;
        data1 = 8'h21;
        exp_q.push_back(mk(2, 8'h21, 1'b1));
        @(negedge w_clk);
        check("early_ready1", {31'd0, ready1}, 1);
        check("early_ready0", {31'd0, ready0}, 0);
        @(posedge w_clk);
        #1;
        valid0 = 1'b1;
        data0 = 8'h13;
        data1 = 8'h22;
        exp_q.push_back(mk(3, 8'h22, 1'b1));
        exp_q.push_back(mk(4, 8'h23, 1'b1));
        exp_q.push_back(mk(5, 8'h24, 1'b1));
        exp_q.push_back(mk(6, 8'h13, 1'b0));
        both_cycles(4);
        valid0 = 1'b0;
        valid1 = 1'b0;
        q_drained("early_q_drained");

        // 70 words with the reader in lockstep: address wraps twice.
        reset_dut();
        prev_gray = '0;
        valid0 = 1'b1;
        for (int k = 0; k < 70; k++) begin
            rptr_gray_sync = gray(k);
            data0 = DW'(k);
            exp_q.push_back(mk(k % 32, k, 1'b0));
            wait_accept(0);
            check("wrap_gray", {26'd0, wptr_gray}, {26'd0, gray(k + 1)});
            check("wrap_one_bit", $countones(wptr_gray ^ prev_gray), 1);
            prev_gray = wptr_gray;
        end
        valid0 = 1'b0;
        q_drained("wrap_q_drained");

        // Reset in the middle of a requester-1 burst.
        rptr_gray_sync = '0;
        reset_dut();
        valid1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data1 = DW'(8'h31 + k);
            exp_q.push_back(mk(k, 8'h31 + k, 1'b1));
            wait_accept(1);
        end
        valid0 = 1'b1;
        data0 = 8'h51;
        data1 = 8'h34;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gray", {26'd0, wptr_gray}, 0);
        check("mid_rst_full", {31'd0, full}, 0);
        check("mid_rst_we", {31'd0, Write_EN}, 0);
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 8'h51, 1'b0));
        @(negedge w_clk);
        check("post_rst_grant0", {31'd0, ready0}, 1);
        @(posedge w_clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        q_drained("mid_q_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
